// File: rtl/ste_stream_controller_pkg.sv
// Shared widths, FSM encoding and report record layout for the STE stream controller.
package ste_stream_controller_pkg;

  localparam int DEF_SYMBOL_WIDTH = 16;
  localparam int DEF_NUM_REPORTS  = 2;
  localparam int DEF_OFFSET_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [DEF_OFFSET_WIDTH-1:0] offset;
    logic [DEF_NUM_REPORTS-1:0]  vector;
  } rep_rec_t;

endpackage

// File: rtl/ste_stream_controller_report_fifo.sv
// Synchronous report FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module ste_report_fifo
  import ste_stream_controller_pkg::*;
#(
  parameter int WIDTH = DEF_OFFSET_WIDTH + DEF_NUM_REPORTS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_s;
  logic             push_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = pop_i && !empty_o;
  assign push_s  = push_i && (!full_o || pop_s);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/ste_stream_controller.sv
// Feeds one symbol stream through the STE array and queues (offset, report) records,
// holding the automaton step whenever a report cannot be stored.
module ste_stream_controller
  import ste_stream_controller_pkg::*;
#(
  parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
  parameter int NUM_REPORTS  = DEF_NUM_REPORTS,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    streamStart,
  input  logic                    inValid,
  input  logic [SYMBOL_WIDTH-1:0] inSymbol,
  input  logic                    inLast,
  output logic                    inReady,
  output logic [SYMBOL_WIDTH-1:0] steSymbol,
  output logic                    steStep,
  output logic                    steClear,
  output logic                    startOfData,
  input  logic [NUM_REPORTS-1:0]  steReport,
  output logic                    repValid,
  input  logic                    repReady,
  output logic [OFFSET_WIDTH-1:0] repOffset,
  output logic [NUM_REPORTS-1:0]  repVector,
  output logic                    busy,
  output logic                    done
);

  localparam int RW = OFFSET_WIDTH + NUM_REPORTS;

  state_t                  state_q, state_d;
  logic                    stage_valid_q, stage_valid_d;
  logic [OFFSET_WIDTH-1:0] stage_offset_q, stage_offset_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [SYMBOL_WIDTH-1:0] symbol_q, symbol_d;

  logic          has_report_s;
  logic          retire_s;
  logic          fire_s;
  logic          push_s;
  logic          pop_s;
  logic          done_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [RW-1:0] fifo_head_s;

  // The retire decision is combinational through steReport, so inReady is too.
  assign has_report_s = (steReport != {NUM_REPORTS{1'b0}});
  assign retire_s     = stage_valid_q && (!has_report_s || !fifo_full_s);
  assign inReady      = (state_q == ST_RUN) && (!stage_valid_q || retire_s);
  assign fire_s       = inValid && inReady;
  assign push_s       = retire_s && has_report_s;
  assign pop_s        = repReady && !fifo_empty_s;

  // Stream sequencing.
  always_comb begin
    state_d = state_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (streamStart) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fire_s && inLast) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!stage_valid_q) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Offset counter and the single-entry stage that presents steSymbol.
  always_comb begin
    offset_d       = offset_q;
    stage_valid_d  = stage_valid_q;
    stage_offset_d = stage_offset_q;
    symbol_d       = symbol_q;
    if (state_q == ST_CLEAR) begin
      offset_d = {OFFSET_WIDTH{1'b0}};
    end else if (fire_s) begin
      offset_d = offset_q + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      offset_d = offset_q;
    end
    if (fire_s) begin
      stage_valid_d  = 1'b1;
      stage_offset_d = offset_q;
      symbol_d       = inSymbol;
    end else if (retire_s) begin
      stage_valid_d  = 1'b0;
    end else begin
      stage_valid_d  = stage_valid_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_IDLE;
      stage_valid_q  <= 1'b0;
      stage_offset_q <= {OFFSET_WIDTH{1'b0}};
      offset_q       <= {OFFSET_WIDTH{1'b0}};
      symbol_q       <= {SYMBOL_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      stage_valid_q  <= stage_valid_d;
      stage_offset_q <= stage_offset_d;
      offset_q       <= offset_d;
      symbol_q       <= symbol_d;
    end
  end

  ste_report_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetN  (resetN),
    .push_i  (push_s),
    .data_i  ({stage_offset_q, steReport}),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign steSymbol   = symbol_q;
  assign steStep     = retire_s;
  assign steClear    = (state_q == ST_CLEAR);
  assign startOfData = stage_valid_q && (stage_offset_q == {OFFSET_WIDTH{1'b0}});
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_s;
  assign repValid    = !fifo_empty_s;

  // Stale head contents are masked so the record outputs read zero when empty.
  always_comb begin
    repOffset = {OFFSET_WIDTH{1'b0}};
    repVector = {NUM_REPORTS{1'b0}};
    if (!fifo_empty_s) begin
      repOffset = fifo_head_s[RW-1:NUM_REPORTS];
      repVector = fifo_head_s[NUM_REPORTS-1:0];
    end else begin
      repOffset = {OFFSET_WIDTH{1'b0}};
      repVector = {NUM_REPORTS{1'b0}};
    end
  end

endmodule
